multi_digit_auto_counter: RTL and testbench

MULTI_DIGIT_AUTO_COUNTER -- requirements
Module: multi_digit_auto_counter

---
 rtl/multi_digit_auto_counter.sv | 156 +++++++++++++++
 tb/tb_multi_digit_auto_counter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_auto_counter.sv
// Multi-digit up/down counter stepped by a programmable rate divider, with load and 7-segment outputs.
// Define BCD_MODE_EN for decimal digits (0..9, loads clamped to 9); otherwise digits count 0..F.
module multi_digit_auto_counter #(
  parameter int          DIGITS    = 2,
  parameter int          DIV_WIDTH = 27,
  parameter int unsigned RATE0     = 1,
  parameter int unsigned RATE1     = 24999999,
  parameter int unsigned RATE2     = 49999999,
  parameter int unsigned RATE3     = 99999999
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          speed,
  input  logic                run,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic [7*DIGITS-1:0] HEX,
  output logic                tick,
  output logic                wrap
);

  localparam int CW = 4 * DIGITS;
`ifdef BCD_MODE_EN
  localparam logic [3:0] DMAX = 4'd9;
`else
  localparam logic [3:0] DMAX = 4'hF;
`endif

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           speed_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic [CW:0]          stepped;

  function automatic logic [DIV_WIDTH-1:0] rate_of(input logic [1:0] s);
    case (s)
      2'd0:    rate_of = DIV_WIDTH'(RATE0);
      2'd1:    rate_of = DIV_WIDTH'(RATE1);
      2'd2:    rate_of = DIV_WIDTH'(RATE2);
      default: rate_of = DIV_WIDTH'(RATE3);
    endcase
  endfunction

  function automatic logic [CW-1:0] load_fix(input logic [CW-1:0] v);
    load_fix = v;
`ifdef BCD_MODE_EN
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) load_fix[4*k +: 4] = 4'd9;
    end
`endif
  endfunction

  // MSB of the result is the carry/borrow out of the top digit, i.e. the wrap flag.
  function automatic logic [CW:0] step_count(input logic [CW-1:0] v, input logic dir_up);
    logic [CW-1:0] r;
    logic          carry;
    logic [3:0]    d;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (carry) begin
        if (dir_up) begin
          if (d >= DMAX) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*k +: 4] = DMAX;
          end else begin
            r[4*k +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    step_count = {carry, r};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign stepped = step_count(count_q, up);

  // Priority: load, then a speed change (reload without stepping), then the divider.
  always_comb begin
    div_d   = div_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_fix(load_value);
      div_d   = rate_of(speed);
    end else if (run) begin
      if (speed != speed_q) begin
        div_d = rate_of(speed);
      end else if (div_q == '0) begin
        div_d   = rate_of(speed);
        count_d = stepped[CW-1:0];
        tick_d  = 1'b1;
        wrap_d  = stepped[CW];
      end else begin
        div_d = div_q - DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      speed_q <= 2'd0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      speed_q <= speed;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

  for (genvar k = 0; k < DIGITS; k++) begin : g_hex
    assign HEX[7*k +: 7] = seg7(count_q[4*k +: 4]);
  end

endmodule

// File: tb/tb_multi_digit_auto_counter.sv
// Bench for multi_digit_auto_counter (2 digits, short rates); covers both BCD_MODE_EN builds.
module tb_multi_digit_auto_counter;

  localparam int R0 = 1;
  localparam int R1 = 5;
  localparam int R2 = 9;
  localparam int R3 = 3;
`ifdef BCD_MODE_EN
  localparam int BASE = 10;
`else
  localparam int BASE = 16;
`endif
  localparam int MAXN = BASE * BASE - 1;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic        run = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  load_value = 8'h00;
  logic [7:0]  count;
  logic [13:0] HEX;
  logic        tick;
  logic        wrap;

  multi_digit_auto_counter #(
    .DIGITS(2), .DIV_WIDTH(27), .RATE0(R0), .RATE1(R1), .RATE2(R2), .RATE3(R3)
  ) dut (
    .clock(clk), .reset(reset), .speed(speed), .run(run), .up(up), .load(load),
    .load_value(load_value), .count(count), .HEX(HEX), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the count is held as a plain number in base BASE.
  int         m_div;
  int         m_num;
  logic [1:0] m_spd;
  logic       m_tick, m_wrap;

  function automatic int rate(input logic [1:0] s);
    case (s)
      2'd0:    return R0;
      2'd1:    return R1;
      2'd2:    return R2;
      default: return R3;
    endcase
  endfunction

  function automatic int to_num(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > BASE - 1) hi = BASE - 1;
    if (lo > BASE - 1) lo = BASE - 1;
    return hi * BASE + lo;
  endfunction

  function automatic logic [7:0] from_num(input int n);
    return {4'(n / BASE), 4'(n % BASE)};
  endfunction

  function automatic logic [13:0] hex_of(input logic [7:0] c);
    return {SEG[c[7:4]], SEG[c[3:0]]};
  endfunction

  task automatic model_reset();
    m_div = 0; m_num = 0; m_spd = 2'd0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_update();
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (load) begin
      m_num = to_num(load_value);
      m_div = rate(speed);
    end else if (run) begin
      if (speed != m_spd) m_div = rate(speed);
      else if (m_div == 0) begin
        m_div  = rate(speed);
        m_tick = 1'b1;
        if (up) begin
          m_wrap = (m_num == MAXN);
          m_num  = (m_num + 1) % (MAXN + 1);
        end else begin
          m_wrap = (m_num == 0);
          m_num  = (m_num + MAXN) % (MAXN + 1);
        end
      end else m_div = m_div - 1;
    end
    m_spd = speed;
  endtask

  task automatic step_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] lv;
    logic       dir_up;
    logic [7:0] exp_load;
    logic [7:0] exp_cnt;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit got;
`ifdef BCD_MODE_EN
    vecs[0] = '{8'h99, 1'b1, 8'h99, 8'h00, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 8'h99, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h99, 1'b1};
    vecs[3] = '{8'h10, 1'b0, 8'h10, 8'h09, 1'b0};
    vecs[4] = '{8'h19, 1'b1, 8'h19, 8'h20, 1'b0};
    vecs[5] = '{8'h42, 1'b1, 8'h42, 8'h43, 1'b0};
    vecs[6] = '{8'hA5, 1'b0, 8'h95, 8'h94, 1'b0};
`else
    vecs[0] = '{8'h99, 1'b1, 8'h99, 8'h9A, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 8'hFF, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 8'hFF, 1'b1};
    vecs[3] = '{8'h10, 1'b0, 8'h10, 8'h0F, 1'b0};
    vecs[4] = '{8'h19, 1'b1, 8'h19, 8'h1A, 1'b0};
    vecs[5] = '{8'h42, 1'b1, 8'h42, 8'h43, 1'b0};
    vecs[6] = '{8'hA5, 1'b0, 8'hA5, 8'hA4, 1'b0};
`endif
    model_reset();

    // Reset holds everything clear even with load and run active.
    load = 1'b1; load_value = 8'h5A; run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'h00);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_hex", 32'(HEX), 32'(14'b1000000_1000000));
    load = 1'b0; run = 1'b0;
    reset = 1'b1;
    model_reset();

    // Free run at speed 0: one step every 2 cycles, first step right away.
    run = 1'b1; up = 1'b1; speed = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      step_cycle();
      chk("run_count", 32'(count), 32'((i + 1) / 2));
      chk("run_tick", 32'(tick), 32'(i % 2));
    end

    // Table of load-then-single-step vectors.
    foreach (vecs[i]) begin
      run = 1'b0; load = 1'b1; load_value = vecs[i].lv; up = vecs[i].dir_up;
      step_cycle();
      chk("tbl_load", 32'(count), 32'(vecs[i].exp_load));
      chk("tbl_load_tick", 32'(tick), 32'h0);
      load = 1'b0; run = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        step_cycle();
        if (tick) got = 1'b1;
      end
      chk("tbl_tick_seen", 32'(got), 32'h1);
      chk("tbl_count", 32'(count), 32'(vecs[i].exp_cnt));
      chk("tbl_wrap", 32'(wrap), 32'(vecs[i].exp_wrap));
      chk("tbl_hex", 32'(HEX), 32'(hex_of(vecs[i].exp_cnt)));
      run = 1'b0;
      step_cycle();
      chk("tbl_tick_pulse", 32'(tick), 32'h0);
      chk("tbl_wrap_pulse", 32'(wrap), 32'h0);
    end

    // Load while paused, then hold for 50 cycles.
    up = 1'b1; run = 1'b0; load = 1'b1; load_value = 8'h42;
    step_cycle();
    chk("pause_load", 32'(count), 32'h42);
    load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step_cycle();
      chk("pause_count", 32'(count), 32'h42);
      chk("pause_tick", 32'(tick), 32'h0);
    end

    // Load lands on the cycle the divider is 0: load wins, next step RATE0+1 later.
    run = 1'b1; load = 1'b1; load_value = 8'h30;
    step_cycle();
    chk("ld0_a", 32'(count), 32'h30);
    load = 1'b0;
    step_cycle();
    chk("ld0_b_tick", 32'(tick), 32'h0);
    load = 1'b1; load_value = 8'h55;
    step_cycle();
    chk("ld0_c_count", 32'(count), 32'h55);
    chk("ld0_c_tick", 32'(tick), 32'h0);
    load = 1'b0;
    step_cycle();
    chk("ld0_d_tick", 32'(tick), 32'h0);
    step_cycle();
    chk("ld0_e_tick", 32'(tick), 32'h1);
    chk("ld0_e_count", 32'(count), 32'h56);

    // Speed change on a cycle that would have stepped: reload, step R1+1 cycles later.
    step_cycle();
    chk("spd_pre_tick", 32'(tick), 32'h0);
    speed = 2'd1;
    step_cycle();
    chk("spd_chg_tick", 32'(tick), 32'h0);
    chk("spd_chg_count", 32'(count), 32'h56);
    for (int i = 0; i < R1; i++) begin
      step_cycle();
      chk("spd_wait_tick", 32'(tick), 32'h0);
    end
    step_cycle();
    chk("spd_step_tick", 32'(tick), 32'h1);
    chk("spd_step_count", 32'(count), 32'h57);
    step_cycle();

    // Asynchronous reset mid-count clears without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h00);
    chk("arst_hex", 32'(HEX), 32'(14'b1000000_1000000));
    chk("arst_tick", 32'(tick), 32'h0);
    @(posedge clk);
    #1;
    speed = 2'd0; run = 1'b0;
    reset = 1'b1;
    model_reset();

    // Randomized run against the reference model.
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: load_value = 8'h00;
        1: load_value = 8'hFF;
        2: load_value = 8'h99;
        default: load_value = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) up = ~up;
      if ($urandom_range(0, 59) == 0) speed = 2'($urandom_range(0, 3));
      step_cycle();
      chk("rnd_count", 32'(count), 32'(from_num(m_num)));
      chk("rnd_tick", 32'(tick), 32'(m_tick));
      chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
      chk("rnd_hex", 32'(HEX), 32'(hex_of(from_num(m_num))));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
